// File: rtl/fp16_psum_norm.sv
// fp16_psum_norm: normalise, round-to-nearest-even and pack a psum into binary16.
// Define SUBNORMAL_EN for gradual underflow; otherwise tiny results flush to signed zero.

module fp16_psum_norm #(
    parameter int FLAG_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [4:0]        in_exp,
    input  logic [12:0]       in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_fp16,
    output logic [FLAG_W-1:0] flags,
    input  logic              flags_clr
);

    logic adv;
    logic xfer;

    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = adv;
    assign xfer     = out_valid & out_ready;

    logic [3:0] lead;
    logic [4:0] e_in;

    always_comb begin
        lead = '0;
        for (int i = 0; i < 13; i++) begin
            if (in_mant[i]) lead = 4'(i);
        end
    end

    assign e_in = (in_exp == 5'd0) ? 5'd1 : in_exp;

    logic              s1_v;
    logic              s1_sign;
    logic              s1_zero;
    logic signed [6:0] s1_e;
    logic [12:0]       s1_mant;
    logic [3:0]        s1_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_e    <= '0;
            s1_mant <= '0;
            s1_sh   <= '0;
        end else if (adv) begin
            s1_v    <= in_valid;
            s1_sign <= in_sign;
            s1_zero <= (in_mant == 13'd0);
            s1_e    <= $signed({2'b0, e_in}) + $signed({3'b0, lead}) - 7'sd10;
            s1_mant <= in_mant;
            s1_sh   <= 4'd12 - lead;
        end
    end

    logic [25:0] nv;
    logic [25:0] wv;
    logic        sub;
    logic [10:0] m11;
    logic        g;
    logic        st;
    logic        inc;
    logic [11:0] rnd;
    logic [5:0]  ef;
    logic [9:0]  frac;
    logic        inx;
    logic        uf;
`ifdef SUBNORMAL_EN
    logic [3:0]  rsh;
`endif

    // Leading one lands on bit 25; bits 25:15 are the 11-bit significand.
    always_comb begin
        nv  = {s1_mant, 13'b0} << s1_sh;
        sub = (s1_e < 7'sd1);
`ifdef SUBNORMAL_EN
        rsh = sub ? 4'(7'sd1 - s1_e) : 4'd0;
        wv  = nv >> rsh;
`else
        wv  = nv;
`endif
        m11 = wv[25:15];
        g   = wv[14];
        st  = |wv[13:0];
        inc = g & (st | m11[0]);
        rnd = {1'b0, m11} + {11'b0, inc};
        inx = g | st;
        uf  = 1'b0;
        if (rnd[11]) begin
            ef   = s1_e[5:0] + 6'd1;
            frac = rnd[10:1];
        end else begin
            ef   = s1_e[5:0];
            frac = rnd[9:0];
        end
        if (sub) begin
`ifdef SUBNORMAL_EN
            ef   = {5'b0, rnd[10]};
            frac = rnd[9:0];
            uf   = inx & ~rnd[10];
`else
            ef   = '0;
            frac = '0;
            inx  = 1'b1;
            uf   = 1'b1;
`endif
        end
    end

    logic       s2_v;
    logic       s2_sign;
    logic       s2_zero;
    logic [5:0] s2_e;
    logic [9:0] s2_frac;
    logic       s2_inx;
    logic       s2_uf;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v    <= 1'b0;
            s2_sign <= 1'b0;
            s2_zero <= 1'b0;
            s2_e    <= '0;
            s2_frac <= '0;
            s2_inx  <= 1'b0;
            s2_uf   <= 1'b0;
        end else if (adv) begin
            s2_v    <= s1_v;
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_e    <= ef;
            s2_frac <= frac;
            s2_inx  <= inx;
            s2_uf   <= uf;
        end
    end

    logic [15:0]       pk;
    logic [FLAG_W-1:0] pf;
    logic [FLAG_W-1:0] out_flg;

    always_comb begin
        if (s2_zero) begin
            pk = 16'h0000;
            pf = 3'b000;
        end else if (s2_e >= 6'd31) begin
            pk = {s2_sign, 15'h7C00};
            pf = 3'b101;
        end else begin
            pk = {s2_sign, s2_e[4:0], s2_frac};
            pf = {s2_inx, s2_uf, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_fp16  <= 16'h0000;
            out_flg   <= '0;
        end else if (adv) begin
            out_valid <= s2_v;
            if (s2_v) begin
                out_fp16 <= pk;
                out_flg  <= pf;
            end
        end
    end

    // A result leaving on the same edge as a clear still records its flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else if (flags_clr) begin
            flags <= xfer ? out_flg : '0;
        end else if (xfer) begin
            flags <= flags | out_flg;
        end
    end

endmodule

// File: doc/fp16_psum_norm.md
Name: fp16_psum_norm

Overview:
- Downstream of the fp16 accumulator. Takes the accumulator's un-normalised partial sum {sign, exp[4:0], mant[12:0]} when accumulation completes.
- Normalises, rounds to nearest-even and packs the result into IEEE-754 binary16 for the output writeback path.
- 3-stage pipeline with valid/ready handshake and sticky exception flags.

Parameters:
- FLAG_W, 3, number of sticky exception flags (fixed order {inexact, underflow, overflow}).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  psum present.
- in_ready  out  1  stage accepts psum this cycle.
- in_sign  in  1  psum sign.
- in_exp  in  5  psum biased exponent (bias 15).
- in_mant  in  13  psum magnitude; hidden-bit weight at bit 10, bits 12:11 are carry headroom.
- out_valid  out  1  fp16 result present.
- out_ready  in  1  consumer accepts result.
- out_fp16  out  16  packed binary16 result.
- flags  out  3  sticky {inexact, underflow, overflow}.
- flags_clr  in  1  clears sticky flags.

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous, active-high.
- Input value = (-1)^in_sign * in_mant * 2^(E-25), where E = in_exp, or E = 1 if in_exp == 0.
- Reset values: all pipeline valid bits 0, out_valid 0, out_fp16 16'h0000, flags 3'b000. Reset mid-operation discards all in-flight data; no partial result appears after reset.
- Handshake: stall = out_valid & ~out_ready.
  - When stall is high, all stages hold. in_ready = ~stall.
  - Transfer occurs when valid & ready are both high on the same edge.
  - Bubbles advance freely when not stalled.
  - out_fp16 is stable while out_valid & ~out_ready.
- Latency: 3 cycles from input transfer to out_valid, with no stall. Throughput is 1 per cycle.
- S1, classify:
  - Leading-one position p of in_mant.
  - p = 12: right shift 2, E+2. p = 11: right shift 1, E+1. p = 10: no shift.
  - p < 10: left shift (10-p), E-(10-p).
  - in_mant == 0: zero class.
- S2, shift and round:
  - 14-bit working field, so shifted-out bits are kept as guard (g) and sticky (s) bits.
  - If normalised E < 1: subnormal path. Extra right shift (1-E), E = 0, shifted bits OR'd into s.
  - Round to nearest-even: increment when g & (s | lsb).
  - A carry out of bit 10 re-normalises: right shift 1, E+1. A subnormal rounding into bit 10 yields E = 1.
  - inexact = g | s.
- S3, pack:
  - Zero class → 16'h0000 (+0 regardless of sign).
  - E ≥ 31 → {sign, 15'h7C00}, overflow set, inexact set.
  - Otherwise {sign, E[4:0], mant[9:0]}.
- Flags:
  - Set (OR) only when a result transfers out.
  - flags_clr clears them. If flags_clr coincides with a setting event, the setting event wins.
  - Reset clears them.
- Underflow: set when the final result is subnormal-inexact or is flushed to zero from a non-zero input.

Optional Feature:
- SUBNORMAL_EN
  - Defined: subnormal path as above; gradual underflow produces exp field 0 with a non-zero fraction.
  - Not defined: any result with normalised E < 1 flushes to {sign, 15'h0000}, with underflow and inexact set. The S2 subnormal shifter is not synthesised.

Test Plan:
- sign=0, exp=15, mant=13'h0400 → out_fp16 16'h3C00 after 3 cycles, flags 000. Also mant=13'h0800 → 16'h4000. Also mant=13'h1800 → 16'h4600.
- Rounding:
  - exp=15, mant=13'h1001 → 16'h4400, inexact set.
  - exp=15, mant=13'h1006 (tie, odd lsb) → 16'h4402.
  - exp=15, mant=13'h1002 (tie, even lsb) → 16'h4400.
- Overflow: sign=1, exp=30, mant=13'h1000 → 16'hFC00, flags overflow and inexact. flags_clr pulse → 000. flags_clr on the same cycle as a new overflow result → overflow stays set.
- Underflow: exp=1, mant=13'h0100.
  - With SUBNORMAL_EN: 16'h0100, no underflow (exact).
  - Without SUBNORMAL_EN: 16'h0000, underflow and inexact set.
  - exp=0, mant=0 → 16'h0000, no flags.
- Back-pressure:
  - Stream 5 back-to-back psums with out_ready held low from cycle 4: in_ready drops and out_fp16 stays stable.
  - On release, all 5 results appear in order with no loss or duplication.
- Reset mid-stream: assert rst with 2 items in flight → out_valid 0 next cycle and no stale output afterwards. The first post-reset input emerges exactly 3 cycles later.
